// File: rtl/ps2_cmd_arbiter.sv
// Two-port arbiter in front of the shared PS/2 transmitter/receiver: grants one requester, sends its
// command byte, waits for the mouse response and reports status. Optional FE resend: PS2_ARB_RESEND_EN.
module ps2_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_i,
  input  logic [7:0] BYTE0_i,
  output logic       DONE0_o,
  input  logic       REQ1_i,
  input  logic [7:0] BYTE1_i,
  output logic       DONE1_o,
  output logic [1:0] RESP_STATUS_o,
  output logic [7:0] RESP_BYTE_o,
  output logic       BUSY_o,
  output logic       SEND_BYTE_o,
  output logic [7:0] BYTE_TO_SEND_o,
  input  logic       BYTE_SENT_i,
  output logic       READ_ENABLE_o,
  input  logic [7:0] BYTE_READ_i,
  input  logic [1:0] BYTE_ERROR_CODE_i,
  input  logic       BYTE_READY_i,
  output logic [2:0] CURRENT_STATE_o
);

  // state     | meaning
  // IDLE      | waiting for a request, arbitration
  // SEND      | one-cycle SEND_BYTE pulse to the transmitter
  // WAIT_SENT | waiting for transmitter completion, with timeout
  // WAIT_RESP | receiver enabled, waiting for FA/FE/FC, with timeout
  // DONE      | DONE pulse to the granted requester, status published
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_SENT = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [1:0] ST_ACK = 2'b00;
  localparam logic [1:0] ST_NAK = 2'b01;
  localparam logic [1:0] ST_ERR = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  state_t               state_q;
  logic                 grant_q;
  logic                 last_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [1:0]           pend_q;
  logic [7:0]           byte_to_send_q;
  logic                 send_byte_q;
  logic                 read_en_q;
  logic                 done0_q;
  logic                 done1_q;
  logic [1:0]           resp_status_q;
  logic [7:0]           resp_byte_q;
  logic                 busy_q;

`ifdef PS2_ARB_RESEND_EN
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_q;
`endif

  logic pick1;
  logic pick_any;
  logic cnt_tmo;

  // last_q = 1 means requester 1 was served last, so requester 0 wins a tie
  assign pick1    = REQ1_i && (!REQ0_i || !last_q);
  assign pick_any = REQ0_i || REQ1_i;
  assign cnt_tmo  = (cnt_q == TO_CNT);

  always_ff @(posedge CLK) begin
    if (RESET || (state_q > S_DONE)) begin
      state_q        <= S_IDLE;
      grant_q        <= 1'b0;
      last_q         <= 1'b1;
      cnt_q          <= '0;
      pend_q         <= 2'b00;
      byte_to_send_q <= 8'h00;
      send_byte_q    <= 1'b0;
      read_en_q      <= 1'b0;
      done0_q        <= 1'b0;
      done1_q        <= 1'b0;
      resp_status_q  <= 2'b00;
      resp_byte_q    <= 8'h00;
      busy_q         <= 1'b0;
`ifdef PS2_ARB_RESEND_EN
      retry_q        <= '0;
`endif
    end else begin
      send_byte_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // the IDLE cycle carrying the DONE pulse does not sample REQ
          if (pick_any && !done0_q && !done1_q) begin
            grant_q        <= pick1;
            byte_to_send_q <= pick1 ? BYTE1_i : BYTE0_i;
            busy_q         <= 1'b1;
            state_q        <= S_SEND;
`ifdef PS2_ARB_RESEND_EN
            retry_q        <= '0;
`endif
          end
        end
        S_SEND: begin
          send_byte_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= S_WAIT_SENT;
        end
        S_WAIT_SENT: begin
          if (BYTE_SENT_i) begin
            cnt_q     <= '0;
            read_en_q <= 1'b1;
            state_q   <= S_WAIT_RESP;
          end else if (cnt_tmo) begin
            pend_q  <= ST_TMO;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        S_WAIT_RESP: begin
          if (BYTE_ERROR_CODE_i != 2'b00) begin
            pend_q    <= ST_ERR;
            read_en_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (BYTE_READY_i) begin
            resp_byte_q <= BYTE_READ_i;
            read_en_q   <= 1'b0;
            state_q     <= S_DONE;
            if (BYTE_READ_i == 8'hFA) begin
              pend_q <= ST_ACK;
            end else begin
              pend_q <= ST_NAK;
`ifdef PS2_ARB_RESEND_EN
              if ((BYTE_READ_i == 8'hFE) && (retry_q < RETRY_MAX)) begin
                retry_q <= retry_q + RETRY_W'(1);
                state_q <= S_SEND;
              end
`endif
            end
          end else if (cnt_tmo) begin
            pend_q    <= ST_TMO;
            read_en_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        S_DONE: begin
          done0_q       <= ~grant_q;
          done1_q       <= grant_q;
          resp_status_q <= pend_q;
          last_q        <= grant_q;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign DONE0_o         = done0_q;
  assign DONE1_o         = done1_q;
  assign RESP_STATUS_o   = resp_status_q;
  assign RESP_BYTE_o     = resp_byte_q;
  assign BUSY_o          = busy_q;
  assign SEND_BYTE_o     = send_byte_q;
  assign BYTE_TO_SEND_o  = byte_to_send_q;
  assign READ_ENABLE_o   = read_en_q;
  assign CURRENT_STATE_o = state_q;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Scoreboard bench for ps2_cmd_arbiter: stimulus pushes expected sends/DONEs, a negedge monitor checks them.
module tb_ps2_cmd_arbiter;
  localparam int TMO = 40;
`ifdef PS2_ARB_RESEND_EN
  localparam int FE_SENDS = 4;
`else
  localparam int FE_SENDS = 1;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ0, REQ1;
  logic [7:0] BYTE0, BYTE1;
  logic       DONE0, DONE1;
  logic [1:0] RESP_STATUS;
  logic [7:0] RESP_BYTE;
  logic       BUSY, SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [2:0] CURRENT_STATE;

  ps2_cmd_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8), .MAX_RETRY(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_i(REQ0), .BYTE0_i(BYTE0), .DONE0_o(DONE0),
    .REQ1_i(REQ1), .BYTE1_i(BYTE1), .DONE1_o(DONE1),
    .RESP_STATUS_o(RESP_STATUS), .RESP_BYTE_o(RESP_BYTE), .BUSY_o(BUSY),
    .SEND_BYTE_o(SEND_BYTE), .BYTE_TO_SEND_o(BYTE_TO_SEND), .BYTE_SENT_i(BYTE_SENT),
    .READ_ENABLE_o(READ_ENABLE), .BYTE_READ_i(BYTE_READ),
    .BYTE_ERROR_CODE_i(BYTE_ERROR_CODE), .BYTE_READY_i(BYTE_READY),
    .CURRENT_STATE_o(CURRENT_STATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       idx;
    logic [1:0] st;
    logic [7:0] b;
  } exp_t;

  logic [7:0] exp_send[$];
  exp_t       exp_done[$];
  exp_t       e;
  logic [7:0] model_last = 8'h00;

  // responder configuration
  bit         rsp_sent_en  = 1'b1;
  bit         rsp_ready_en = 1'b1;
  bit         rsp_stray    = 1'b0;
  logic [7:0] rsp_byte     = 8'hFA;
  logic [1:0] rsp_err      = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // which: 0 SEND_BYTE, 1 DONE0, 2 DONE1, 4 READ_ENABLE
  task automatic wait_sig(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if ((which == 0 && SEND_BYTE) || (which == 1 && DONE0) ||
          (which == 2 && DONE1) || (which == 4 && READ_ENABLE)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_%0d: event not seen within %0d cycles", which, limit);
    end
  endtask

  task automatic run_one(input bit idx, input logic [7:0] b, input int nsend,
                         input logic [1:0] st, input bit chk_lat,
                         output int s_cyc, output int d_cyc);
    bit ok;
    int r_cyc;
    for (int i = 0; i < nsend; i++) exp_send.push_back(b);
    exp_done.push_back({idx, st, model_last});
    @(posedge CLK); #1;
    if (idx) begin BYTE1 = b; REQ1 = 1'b1; end
    else     begin BYTE0 = b; REQ0 = 1'b1; end
    r_cyc = cyc;
    wait_sig(0, 50, ok);
    s_cyc = cyc;
    if (chk_lat && ok) chk("send_latency", s_cyc - r_cyc, 2);
    wait_sig(idx ? 2 : 1, 3000, ok);
    d_cyc = cyc;
    if (idx) REQ1 = 1'b0; else REQ0 = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    model_last = 8'h00;
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (!RESET) begin
      if (SEND_BYTE) begin
        if (exp_send.size() == 0) chk("send_unexpected", SEND_BYTE, 0);
        else chk("byte_to_send", BYTE_TO_SEND, exp_send.pop_front());
      end
      if (DONE0 || DONE1) begin
        chk("done_onehot", DONE0 & DONE1, 0);
        if (exp_done.size() == 0) chk("done_unexpected", {DONE1, DONE0}, 0);
        else begin
          e = exp_done.pop_front();
          chk("done_idx", DONE1, e.idx);
          chk("resp_status", RESP_STATUS, e.st);
          chk("resp_byte", RESP_BYTE, e.b);
        end
      end
    end
  end

  // transmitter/receiver model
  initial begin
    BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00;
    forever begin
      @(negedge CLK);
      if (SEND_BYTE && !RESET) begin
        if (rsp_stray) begin
          BYTE_READ = 8'hFA; BYTE_READY = 1'b1;
          @(posedge CLK); #1 BYTE_READY = 1'b0;
        end
        if (rsp_sent_en) begin
          repeat (10) @(posedge CLK);
          #1 BYTE_SENT = 1'b1;
          @(posedge CLK); #1 BYTE_SENT = 1'b0;
          if (rsp_ready_en) begin
            repeat (2) @(posedge CLK);
            #1 BYTE_READ = rsp_byte; BYTE_ERROR_CODE = rsp_err; BYTE_READY = 1'b1;
            @(posedge CLK); #1 BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int s, d;
    RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; BYTE0 = 8'h00; BYTE1 = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", CURRENT_STATE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done0", DONE0, 0);
    chk("rst_done1", DONE1, 0);
    chk("rst_send", SEND_BYTE, 0);
    chk("rst_read_en", READ_ENABLE, 0);
    chk("rst_status", RESP_STATUS, 0);
    chk("rst_resp_byte", RESP_BYTE, 0);
    chk("rst_byte_to_send", BYTE_TO_SEND, 0);
    RESET = 1'b0;

    // basic ACK on port 0 with grant latency
    rsp_byte = 8'hFA; model_last = 8'hFA;
    run_one(1'b0, 8'hFF, 1, 2'b00, 1'b1, s, d);

    // round robin under contention, starting from the reset pointer
    pulse_reset();
    model_last = 8'hFA;
    for (int k = 0; k < 4; k++) begin
      exp_send.push_back((k % 2 == 0) ? 8'h11 : 8'h22);
      exp_done.push_back({(k % 2 == 1), 2'b00, 8'hFA});
    end
    @(posedge CLK); #1;
    BYTE0 = 8'h11; BYTE1 = 8'h22; REQ0 = 1'b1; REQ1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge CLK);
        if (DONE0 || DONE1) begin ok = 1'b1; break; end
      end
      if (!ok) chk("rr_done_timeout", DONE0 | DONE1, 1);
      if (DONE1) REQ1 = 1'b0; else REQ0 = 1'b0;
      if (k < 2) begin
        @(posedge CLK); #1;
        if (!REQ1 && k == 1) REQ1 = 1'b1;
        if (!REQ0 && k == 0) REQ0 = 1'b1;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (3) @(posedge CLK);

    // transmitter never completes: timeout status
    rsp_sent_en = 1'b0;
    run_one(1'b1, 8'hF3, 1, 2'b11, 1'b0, s, d);
    chk("tmo_sent_window", ((d - s) >= TMO + 2) && ((d - s) <= TMO + 4), 1);
    rsp_sent_en = 1'b1;

    // receive error has priority over a same-cycle FA
    rsp_err = 2'b01; rsp_byte = 8'hFA;
    run_one(1'b0, 8'hE8, 1, 2'b10, 1'b0, s, d);
    rsp_err = 2'b00;

    // stray byte while receiver disabled is ignored; FC is a NAK
    rsp_stray = 1'b1; rsp_byte = 8'hFC; model_last = 8'hFC;
    run_one(1'b1, 8'hF2, 1, 2'b01, 1'b0, s, d);
    rsp_stray = 1'b0;

    // no response byte: timeout in WAIT_RESP keeps the last received byte
    rsp_ready_en = 1'b0;
    run_one(1'b1, 8'hE6, 1, 2'b11, 1'b0, s, d);
    rsp_ready_en = 1'b1;

    // FE responses: resend behaviour depends on build
    rsp_byte = 8'hFE; model_last = 8'hFE;
    run_one(1'b0, 8'hC8, FE_SENDS, 2'b01, 1'b0, s, d);

    // reset during WAIT_RESP aborts silently
    rsp_ready_en = 1'b0;
    exp_send.push_back(8'hF4);
    @(posedge CLK); #1 BYTE0 = 8'hF4; REQ0 = 1'b1;
    wait_sig(4, 100, ok);
    @(posedge CLK); #1 RESET = 1'b1; REQ0 = 1'b0;
    @(posedge CLK); #1;
    chk("abort_state", CURRENT_STATE, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_read_en", READ_ENABLE, 0);
    chk("abort_done0", DONE0, 0);
    chk("abort_status", RESP_STATUS, 0);
    chk("abort_resp_byte", RESP_BYTE, 0);
    RESET = 1'b0;
    model_last = 8'h00;
    repeat (60) @(posedge CLK);
    rsp_ready_en = 1'b1; rsp_byte = 8'hFA; model_last = 8'hFA;
    run_one(1'b0, 8'hF5, 1, 2'b00, 1'b1, s, d);

    repeat (5) @(posedge CLK);
    chk("send_queue_drained", exp_send.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_cmd_arbiter.md
Name: ps2_cmd_arbiter

Overview:
- Shares the single PS/2 host transmitter/receiver pair between two command requesters: the mouse init/stream master state machine on port 0 and a processor-side configuration port on port 1 (sample rate, resolution, etc.).
- Grants one requester at a time and sends its byte. Waits for the mouse response byte (FA/FE/FC) with a timeout, then returns a status code and a one-cycle DONE pulse to the granted requester.
- Sits between the requesters and the PS/2 transmitter/receiver blocks.

Parameters:
- TIMEOUT_CYCLES, 500000: maximum cycles allowed in WAIT_SENT or WAIT_RESP (10 ms at 50 MHz).
- CNT_WIDTH, 24: timeout counter width; must hold TIMEOUT_CYCLES.
- MAX_RETRY, 3: maximum automatic retransmissions after FE (only with the optional feature).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- REQ0  in  1  requester 0 request, level; held until DONE0
- BYTE0  in  8  requester 0 command byte; stable while REQ0=1
- DONE0  out  1  one-cycle pulse, requester 0 transaction finished
- REQ1  in  1  requester 1 request, level
- BYTE1  in  8  requester 1 command byte
- DONE1  out  1  one-cycle pulse, requester 1 transaction finished
- RESP_STATUS  out  2  00 ACK(FA), 01 NAK (FC/FE/other byte), 10 receive error, 11 timeout; valid while DONEx=1 and held until the next DONE
- RESP_BYTE  out  8  last response byte received (00 if none)
- BUSY  out  1  high whenever state != IDLE
- SEND_BYTE  out  1  one-cycle pulse to the transmitter
- BYTE_TO_SEND  out  8  byte to the transmitter
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  receiver enable
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver error; nonzero means error
- BYTE_READY  in  1  receiver byte-valid pulse
- CURRENT_STATE  out  3  debug state encoding

Behaviour:
- All outputs are registered.
- Reset values:
  - State IDLE (0). All other outputs 0, including RESP_STATUS, RESP_BYTE and BYTE_TO_SEND.
  - Last-grant pointer = 1, so requester 0 wins the first tie.
  - Retry count 0.
- States: IDLE=0, SEND=1, WAIT_SENT=2, WAIT_RESP=3, DONE=4. Codes 5-7 go to IDLE and clear all outputs.
- IDLE:
  - Single request: grant it.
  - Both requesting: round-robin; grant the requester not granted last.
  - On grant: latch the grant index, latch BYTEx into BYTE_TO_SEND, clear the retry count, go to SEND.
- SEND: set SEND_BYTE for exactly one cycle, clear the counter, go to WAIT_SENT.
  - Latency: REQ sampled in IDLE at cycle t -> SEND_BYTE=1 at cycle t+2.
- WAIT_SENT:
  - On BYTE_SENT: clear the counter and go to WAIT_RESP.
  - Otherwise, if the counter reaches TIMEOUT_CYCLES: status 11, go to DONE.
  - Otherwise increment the counter.
- WAIT_RESP: READ_ENABLE=1 for the whole state.
  - Priority 1: BYTE_ERROR_CODE != 0 -> status 10.
  - Priority 2: BYTE_READY -> record RESP_BYTE, then map the byte:
    - FA -> status 00.
    - FE -> retry handling (optional feature).
    - Any other byte -> status 01.
  - Priority 3: counter reaches TIMEOUT_CYCLES -> status 11.
  - A byte arriving in the same cycle as the timeout wins over the timeout.
- DONE: pulse DONEx for the granted index for one cycle, update the last-grant pointer, go to IDLE.
- Bytes presented while READ_ENABLE=0 are ignored.
- A requester dropping REQ mid-transaction does not abort it; DONE still pulses.
- A new REQ on the non-granted port waits.
- RESET at any point aborts with no DONE pulse and returns all outputs to reset values.
- A requester must clear REQ on the clock edge following DONE. The arbiter samples REQ again in the IDLE cycle after DONE.
- Counter saturates at TIMEOUT_CYCLES; it never wraps.

Optional Feature:
- Macro: PS2_ARB_RESEND_EN.
- Defined:
  - FE in WAIT_RESP with retry count < MAX_RETRY: increment the retry count and go to SEND, resending the same BYTE_TO_SEND. No DONE is issued.
  - FE with retry count == MAX_RETRY: status 01.
- Undefined: FE immediately gives status 01. The retry counter and the MAX_RETRY logic are not built.

Test Plan:
- REQ0=1, BYTE0=FF; BYTE_SENT pulsed 10 cycles after SEND_BYTE; BYTE_READY with FA -> SEND_BYTE at t+2 with BYTE_TO_SEND=FF; DONE0 once; RESP_STATUS=00; RESP_BYTE=FA; DONE1 never asserts.
- REQ0 and REQ1 asserted in the same cycle, both re-requesting after each DONE -> grants alternate 0,1,0,1; BYTE_TO_SEND alternates BYTE0/BYTE1.
- REQ1=1, BYTE1=F3; BYTE_SENT never pulses -> DONE1 exactly TIMEOUT_CYCLES+3 cycles after SEND_BYTE (±1 allowed for counter-compare alignment); RESP_STATUS=11.
- In WAIT_RESP, BYTE_ERROR_CODE=01 in the same cycle as BYTE_READY with FA -> RESP_STATUS=10.
- With PS2_ARB_RESEND_EN: respond FE four times -> four SEND_BYTE pulses of the same byte, then DONE with RESP_STATUS=01 and RESP_BYTE=FE. Without the macro -> one SEND_BYTE, then status 01.
- RESET asserted during WAIT_RESP -> next cycle: state 0, BUSY=0, no DONE pulse; next REQ0 is served normally.
